// File: rtl/addsubt_arb_pkg.sv
// Shared types and constants for the add/subtract unit arbiter.
package addsubt_arb_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned DEFAULT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_HOLD   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Circular first-one finder starting at rr_ptr; one-hot winner, zero when nothing pending.
// With ADDSUBT_ARB_FIXED_PRIO_EN defined it becomes a plain lowest-index picker.
module rr_priority_picker #(
  parameter int unsigned N_REQ = 2
`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
  ,
  parameter int unsigned PTR_W = 1
`endif
) (
  input  logic [N_REQ-1:0] pending,
`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0] rr_ptr,
`endif
  output logic [N_REQ-1:0] winner
);

  logic found;

  // First pass covers [rr_ptr, N_REQ-1]; second pass wraps around to index 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && pending[i] && (i >= int'(rr_ptr))) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
`endif
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && pending[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_subt_arbiter.sv
// Shares one floating-point add/subtract unit among N_REQ requesters.
// Define ADDSUBT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module add_subt_arbiter
  import addsubt_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = DEFAULT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_beg,
  input  logic [N_REQ*W-1:0] req_op_a,
  input  logic [N_REQ*W-1:0] req_op_b,
  input  logic [N_REQ-1:0]   req_operation,
  input  logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       req_result,
  output logic [N_REQ-1:0]   grant,
  output logic               au_beg,
  output logic [W-1:0]       au_op_a,
  output logic [W-1:0]       au_op_b,
  output logic               au_operation,
  output logic               au_ack,
  input  logic               au_ready,
  input  logic [W-1:0]       au_result
);

  if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_cfg
    $error("add_subt_arbiter: N_REQ must be in 2..8");
  end

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] set_vec, clr_vec;
  logic [W-1:0]     slot_a [N_REQ];
  logic [W-1:0]     slot_b [N_REQ];
  logic [N_REQ-1:0] slot_op;
  logic [N_REQ-1:0] winner;
  logic [N_REQ-1:0] grant_d;
  logic [N_REQ-1:0] req_ready_d;
  logic [W-1:0]     result_d;
  logic [W-1:0]     op_a_d, op_b_d;
  logic             operation_d;
  logic             au_beg_d, au_ack_d;

`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] g_idx;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner)
  );

  // Binary index of the current owner, used to advance the rotation.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant[i]) g_idx = PTR_W'(i);
    end
  end
`else
  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .pending (pending_q),
    .winner  (winner)
  );
`endif

  // A new pulse is accepted when the slot is free or being released this cycle.
  always_comb begin
    set_vec   = req_beg & (~pending_q | clr_vec);
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin : capture
    if (reset) begin
      pending_q <= '0;
      slot_op   <= '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        slot_a[i] <= '0;
        slot_b[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (set_vec[i]) begin
          slot_a[i]  <= req_op_a[i*W +: W];
          slot_b[i]  <= req_op_b[i*W +: W];
          slot_op[i] <= req_operation[i];
        end
      end
    end
  end

  // Next state plus the values every registered output takes on the next edge.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    clr_vec     = '0;
    result_d    = req_result;
`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          grant_d = winner;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (au_ready) begin
          result_d = au_result;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: state_d = ST_HOLD;
      ST_HOLD: begin
        if (|(req_ack & grant)) begin
          clr_vec = grant;
          grant_d = '0;
`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
          rr_ptr_d = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
`endif
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    au_beg_d    = (state_d == ST_LAUNCH);
    au_ack_d    = (state_d == ST_ACK);
    req_ready_d = (state_d == ST_HOLD) ? grant_d : '0;

    op_a_d      = '0;
    op_b_d      = '0;
    operation_d = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_d[i]) begin
        op_a_d      = op_a_d | slot_a[i];
        op_b_d      = op_b_d | slot_b[i];
        operation_d = operation_d | slot_op[i];
      end
    end
  end

  always_ff @(posedge clk) begin : fsm_regs
    if (reset) begin
      state_q      <= ST_IDLE;
      grant        <= '0;
      req_ready    <= '0;
      req_result   <= '0;
      au_beg       <= 1'b0;
      au_ack       <= 1'b0;
      au_op_a      <= '0;
      au_op_b      <= '0;
      au_operation <= 1'b0;
`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant        <= grant_d;
      req_ready    <= req_ready_d;
      req_result   <= result_d;
      au_beg       <= au_beg_d;
      au_ack       <= au_ack_d;
      au_op_a      <= op_a_d;
      au_op_b      <= op_b_d;
      au_operation <= operation_d;
`ifndef ADDSUBT_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_add_subt_arbiter.sv
// Directed bench for add_subt_arbiter with a transaction scoreboard and a modelled add/sub unit.
module tb_add_subt_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_beg;
  logic [N*W-1:0] req_op_a;
  logic [N*W-1:0] req_op_b;
  logic [N-1:0]   req_operation;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   req_result;
  logic [N-1:0]   grant;
  logic           au_beg;
  logic [W-1:0]   au_op_a;
  logic [W-1:0]   au_op_b;
  logic           au_operation;
  logic           au_ack;
  logic           au_ready;
  logic [W-1:0]   au_result;

  add_subt_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_beg       (req_beg),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .req_operation (req_operation),
    .req_ack       (req_ack),
    .req_ready     (req_ready),
    .req_result    (req_result),
    .grant         (grant),
    .au_beg        (au_beg),
    .au_op_a       (au_op_a),
    .au_op_b       (au_op_b),
    .au_operation  (au_operation),
    .au_ack        (au_ack),
    .au_ready      (au_ready),
    .au_result     (au_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // push: 0 = none, 1 = back of scoreboard, 2 = front of scoreboard
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] res, input int push);
    txn_t t;
    req_beg[i]            = 1'b1;
    req_op_a[i*W +: W]    = a;
    req_op_b[i*W +: W]    = b;
    req_operation[i]      = op;
    t.idx = i; t.a = a; t.b = b; t.op = op; t.res = res;
    if (push == 1) sb.push_back(t);
    else if (push == 2) sb.push_front(t);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_au_beg"}, 32'(au_beg), 32'h0);
    check({tag, "_au_ack"}, 32'(au_ack), 32'h0);
    check({tag, "_au_op_a"}, au_op_a, 32'h0);
    check({tag, "_au_op_b"}, au_op_b, 32'h0);
    check({tag, "_au_operation"}, 32'(au_operation), 32'h0);
    check({tag, "_req_result"}, req_result, 32'h0);
  endtask

  task automatic wait_au_beg();
    int n;
    n = 0;
    while (au_beg !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("au_beg_seen", 32'(au_beg), 32'h1);
  endtask

  // Plays the unit: answers 5 cycles after au_beg, then walks the arbiter into HOLD.
  task automatic serve_to_hold();
    txn_t t;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(sb.size()), 32'h1);
      return;
    end
    t = sb.pop_front();
    wait_au_beg();
    check("grant", 32'(grant), 32'(onehot(t.idx)));
    check("au_op_a", au_op_a, t.a);
    check("au_op_b", au_op_b, t.b);
    check("au_operation", 32'(au_operation), 32'(t.op));
    tick();
    check("au_beg_one_cycle", 32'(au_beg), 32'h0);
    repeat (4) tick();
    check("au_op_a_stable", au_op_a, t.a);
    check("au_op_b_stable", au_op_b, t.b);
    au_ready  = 1'b1;
    au_result = t.res;
    tick();
    check("au_ack", 32'(au_ack), 32'h1);
    check("req_ready_not_yet", 32'(req_ready), 32'h0);
    au_ready  = 1'b0;
    au_result = 32'hDEADBEEF;
    tick();
    check("au_ack_pulse", 32'(au_ack), 32'h0);
    check("req_ready", 32'(req_ready), 32'(onehot(t.idx)));
    check("req_result", req_result, t.res);
  endtask

  task automatic do_ack(input int i);
    req_ack[i] = 1'b1;
    tick();
    req_ack = '0;
    check("ack_req_ready_clr", 32'(req_ready), 32'h0);
    check("ack_grant_clr", 32'(grant), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_beg = '0; req_op_a = '0; req_op_b = '0;
    req_operation = '0; req_ack = '0; au_ready = 1'b0; au_result = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Single request: 1.0 + 2.0 = 3.0, au_beg two cycles after the pulse.
    issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1);
    tick();
    req_beg = '0;
    check("lat_t1_au_beg", 32'(au_beg), 32'h0);
    tick();
    check("lat_t2_au_beg", 32'(au_beg), 32'h1);
    serve_to_hold();
    do_ack(0);

    // Re-pulse of requester 1 while pending keeps the original operands.
    issue(1, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 1);
    tick();
    issue(1, 32'h11111111, 32'h22222222, 1'b0, 32'h0, 0);
    tick();
    req_beg = '0;
    serve_to_hold();
    do_ack(1);

    // Simultaneous requests with the rotation back at requester 0.
    issue(0, 32'h41200000, 32'h40000000, 1'b1, 32'h41000000, 1);
    issue(1, 32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 1);
    tick();
    req_beg = '0;
    serve_to_hold();
    // Ack from the non-owner is ignored.
    req_ack = 2'b10;
    tick();
    req_ack = '0;
    check("foreign_ack_ready", 32'(req_ready), 32'h1);
    check("foreign_ack_grant", 32'(grant), 32'h1);
    check("foreign_ack_result", req_result, 32'h41000000);
    // Owner acks while re-requesting in the same cycle.
    req_ack[0] = 1'b1;
`ifdef ADDSUBT_ARB_FIXED_PRIO_EN
    issue(0, 32'h42000000, 32'h3F800000, 1'b0, 32'h42040000, 2);
`else
    issue(0, 32'h42000000, 32'h3F800000, 1'b0, 32'h42040000, 1);
`endif
    tick();
    req_ack = '0;
    req_beg = '0;
    check("gap_grant", 32'(grant), 32'h0);
    check("gap_req_ready", 32'(req_ready), 32'h0);
    tick();
`ifdef ADDSUBT_ARB_FIXED_PRIO_EN
    check("next_grant", 32'(grant), 32'h1);
`else
    check("next_grant", 32'(grant), 32'h2);
`endif
    serve_to_hold();
    req_ack = grant;
    tick();
    req_ack = '0;
    check("second_ack_grant", 32'(grant), 32'h0);
    serve_to_hold();
    req_ack = grant;
    tick();
    req_ack = '0;
    check("third_ack_grant", 32'(grant), 32'h0);

    // Reset in WAIT aborts everything; a late au_ready is ignored.
    issue(0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h0, 0);
    tick();
    req_beg = '0;
    wait_au_beg();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    au_ready  = 1'b1;
    au_result = 32'hCAFEF00D;
    repeat (4) begin
      tick();
      check("late_ready_ack", 32'(au_ack), 32'h0);
      check("late_ready_beg", 32'(au_beg), 32'h0);
    end
    check("late_ready_result", req_result, 32'h0);
    au_ready = 1'b0;

    // Service resumes normally after the abort.
    issue(1, 32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000, 1);
    tick();
    req_beg = '0;
    serve_to_hold();
    do_ack(1);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
